// File: rtl/ann_pkg.sv
// ann_pkg: shared Q16.16 constants and layer FSM states
package ann_pkg;
    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;
    localparam logic [31:0] Q_ONE = 32'h0001_0000;
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    typedef enum logic [1:0] {IDLE, ACC, FINISH} state_t;
endpackage

// File: rtl/ann_sat_relu.sv
// ann_sat_relu: scales a wide Q(2F) sum back to Q16.16 with ReLU and saturation
module ann_sat_relu #(
    parameter int W      = 68,
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic signed [W-1:0]      x,
    output logic        [DATA_W-1:0] y
);
    logic signed [W-1:0] r;
    // negative clamps to zero; anything at or above bit DATA_W-1 clamps to max positive
    always_comb begin
        r = x >>> FRAC_W;
        y = x[W-1] ? '0 : |r[W-1:DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}} : r[DATA_W-1:0];
    end
endmodule

// File: rtl/layer_rx_mac.sv
// layer_rx_mac: serial activation receiver with MAC, bias, saturation and ReLU
module layer_rx_mac #(
    parameter int N_IN   = 3,
    parameter int DATA_W = ann_pkg::DATA_W,
    parameter int FRAC_W = ann_pkg::FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic [N_IN*DATA_W-1:0]   w_flat,
    input  logic [DATA_W-1:0]        bias,
    output logic [DATA_W-1:0]        out,
    output logic                     done,
    output logic                     busy,
    output logic                     overrun
);
    import ann_pkg::*;
    localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
    localparam int SUM_W = ACC_W + 1;
    localparam int IDX_W = N_IN > 1 ? $clog2(N_IN) : 1;
    state_t state, state_nx;
    logic [IDX_W-1:0] idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [2*DATA_W-1:0] a_x, w_x, prod;
    logic signed [SUM_W-1:0] sum;
    logic [DATA_W-1:0] res;
    logic accept, last;
    // words are taken in every state except FINISH; the product is formed at full width
    always_comb begin
        accept = in_valid && state != FINISH;
        last = idx == IDX_W'(N_IN-1);
        a_x = {{DATA_W{in_data[DATA_W-1]}}, in_data};
        w_x = {{DATA_W{w_flat[idx*DATA_W+DATA_W-1]}}, w_flat[idx*DATA_W +: DATA_W]};
        prod = a_x * w_x;
        sum = {acc[ACC_W-1], acc} + {{(SUM_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
        state_nx = state == FINISH ? IDLE : accept ? (last ? FINISH : ACC) : state;
    end
    ann_sat_relu #(.W(SUM_W), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_sat (.x(sum), .y(res));
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    // accumulator, word index, result register and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            acc     <= '0;
            out     <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            busy    <= state_nx != IDLE;
            done    <= state == FINISH;
            overrun <= overrun | (in_valid && state == FINISH);
            if (state == FINISH) begin
                out <= res;
                acc <= '0;
            end else if (accept) begin
                acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
                idx <= last ? '0 : idx + 1'b1;
            end
        end
    end
endmodule
